// File: rtl/vram_arbiter_if.sv
// Signal bundle joining the VRAM arbiter to the scanout fetcher, the command write FIFO and the SRAM port.
interface vram_arbiter_if #(
  parameter int AWIDTH = 19,
  parameter int DWIDTH = 8
);
  logic              ScanReq;
  logic [AWIDTH-1:0] ScanAddr;
  logic [DWIDTH-1:0] ScanData;
  logic              ScanValid;
  logic              CmdHasData;
  logic [AWIDTH-1:0] CmdAddr;
  logic [DWIDTH-1:0] CmdData;
  logic              CmdPop;
  logic [AWIDTH-1:0] MemAddr;
  logic [DWIDTH-1:0] MemDataOut;
  logic [DWIDTH-1:0] MemDataIn;
  logic              MemWe;
  logic              MemOe;

  modport master (
    output ScanReq, ScanAddr, CmdHasData, CmdAddr, CmdData, MemDataIn,
    input  ScanData, ScanValid, CmdPop, MemAddr, MemDataOut, MemWe, MemOe
  );

  modport slave (
    input  ScanReq, ScanAddr, CmdHasData, CmdAddr, CmdData, MemDataIn,
    output ScanData, ScanValid, CmdPop, MemAddr, MemDataOut, MemWe, MemOe
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads beat queued writes; each access holds MemOe/MemWe for
// ACCESS_CYCLES cycles then one idle turnaround cycle. VRAM_STARVE_GUARD_EN bounds write starvation.
module vram_arbiter #(
  parameter int AWIDTH        = 19,
  parameter int DWIDTH        = 8,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 16
) (
  input logic           i_clk,
  input logic           i_reset,
  vram_arbiter_if.slave bus
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_dout;
  logic              r_mem_we;
  logic              r_mem_oe;
  logic [DWIDTH-1:0] r_scan_data;
  logic              r_scan_valid;
  logic              r_cmd_pop;

  logic w_write_first;
  logic w_grant_write;
  logic w_grant_read;

`ifdef VRAM_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_streak;
  assign w_write_first = (r_streak == SW'(STARVE_LIMIT));
`else
  assign w_write_first = 1'b0;
`endif

  // A pending write overrides scan priority only once the scan streak has hit the limit.
  assign w_grant_write = bus.CmdHasData && (!bus.ScanReq || w_write_first);
  assign w_grant_read  = bus.ScanReq && !w_grant_write;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_dout   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_oe     <= 1'b0;
      r_scan_data  <= '0;
      r_scan_valid <= 1'b0;
      r_cmd_pop    <= 1'b0;
`ifdef VRAM_STARVE_GUARD_EN
      r_streak     <= '0;
`endif
    end else begin
      r_scan_valid <= 1'b0;
      r_cmd_pop    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_read) begin
            r_mem_addr <= bus.ScanAddr;
            r_mem_oe   <= 1'b1;
            r_cnt      <= CNT_LOAD;
            r_state    <= READ;
`ifdef VRAM_STARVE_GUARD_EN
            r_streak   <= bus.CmdHasData ? r_streak + 1'b1 : '0;
`endif
          end else if (w_grant_write) begin
            r_mem_addr <= bus.CmdAddr;
            r_mem_dout <= bus.CmdData;
            r_mem_we   <= 1'b1;
            r_cmd_pop  <= 1'b1;
            r_cnt      <= CNT_LOAD;
            r_state    <= WRITE;
`ifdef VRAM_STARVE_GUARD_EN
            r_streak   <= '0;
`endif
          end
        end
        READ: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_scan_data  <= bus.MemDataIn;
            r_scan_valid <= 1'b1;
            r_mem_oe     <= 1'b0;
            r_state      <= IDLE;
          end
        end
        WRITE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_mem_we <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
          r_mem_oe <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.MemAddr    = r_mem_addr;
  assign bus.MemDataOut = r_mem_dout;
  assign bus.MemWe      = r_mem_we;
  assign bus.MemOe      = r_mem_oe;
  assign bus.ScanData   = r_scan_data;
  assign bus.ScanValid  = r_scan_valid;
  assign bus.CmdPop     = r_cmd_pop;

endmodule
